product_list_scheduler: RTL and testbench

Owns the 12-entry product list that feeds the on-screen text datapath via the packed 48-bit product_IDS bus. Slot 0 drives product_IDS[47:44] and is the top display line; slot 11 drives [3:0].
Accepts add, delete and clear requests from the sale-terminal keypad/FSM, and keeps the list compacted. A delete is a multi-cycle shift.
Edits go to a working copy. The working copy is committed to the display bus only at a frame-boundary pixel, so the VGA text never tears mid-frame.

---
 rtl/product_list_scheduler.sv | 135 +++++++++++++
 tb/tb_product_list_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/product_list_scheduler.sv
// Owns the compacted working product list and commits it to the display bus
// only at the frame-boundary pixel so the text overlay never tears.
module product_list_scheduler #(
  parameter int               N_SLOTS      = 12,
  parameter int               ID_W         = 4,
  parameter logic [ID_W-1:0]  EMPTY_CODE   = 4'hF,
  parameter logic [9:0]       COMMIT_LINE  = 10'd480,
  parameter logic [10:0]      COMMIT_PIXEL = 11'd0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      add_valid,
  input  logic [ID_W-1:0]           add_id,
  output logic                      add_ready,
  input  logic                      del_valid,
  input  logic [3:0]                del_index,
  output logic                      del_ready,
  input  logic                      clr,
  input  logic [10:0]               H_counter,
  input  logic [9:0]                V_counter,
  output logic [N_SLOTS*ID_W-1:0]   product_IDS,
  output logic [3:0]                item_count,
  output logic                      full,
  output logic                      empty,
  output logic                      busy,
  output logic                      err
);

  localparam logic [3:0] NS = 4'(N_SLOTS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                ptr_q, ptr_d, ptr_nx;
  logic [3:0]                count_q, count_d;
  logic                      dirty_q, dirty_d;
  logic                      err_q, err_d;
  logic [ID_W-1:0]           slots_q [N_SLOTS];
  logic [ID_W-1:0]           slots_d [N_SLOTS];
  logic [N_SLOTS*ID_W-1:0]   ids_q, ids_d, list_w;
  logic                      commit;

  // Slot 0 is the top display line, so it lands in the MSBs.
  always_comb begin
    list_w = '0;
    for (int i = 0; i < N_SLOTS; i++)
      list_w[(N_SLOTS-1-i)*ID_W +: ID_W] = slots_q[i];
  end

  assign ptr_nx = ptr_q + 4'd1;
  assign commit = (V_counter == COMMIT_LINE) && (H_counter == COMMIT_PIXEL) &&
                  (state_q == IDLE) && dirty_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    dirty_d = dirty_q;
    err_d   = 1'b0;
    ids_d   = ids_q;
    slots_d = slots_q;

    // Commit samples the pre-edit list; any edit this cycle re-sets dirty below.
    if (commit) begin
      ids_d   = list_w;
      dirty_d = 1'b0;
    end

    if (clr) begin
      for (int i = 0; i < N_SLOTS; i++) slots_d[i] = EMPTY_CODE;
      count_d = '0;
      state_d = IDLE;
      dirty_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (del_valid) begin
            if (del_index >= count_q) begin
              err_d = 1'b1;
            end else begin
              ptr_d   = del_index;
              state_d = SHIFT;
            end
          end else if (add_valid && (count_q != NS)) begin
            slots_d[count_q] = add_id;
            count_d          = count_q + 4'd1;
            dirty_d          = 1'b1;
          end
        end
        SHIFT: begin
          if (ptr_q == count_q - 4'd1) begin
            slots_d[ptr_q] = EMPTY_CODE;
            count_d        = count_q - 4'd1;
            dirty_d        = 1'b1;
            state_d        = IDLE;
          end else begin
            slots_d[ptr_q] = slots_q[ptr_nx];
            ptr_d          = ptr_nx;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      dirty_q <= 1'b0;
      err_q   <= 1'b0;
      ids_q   <= {N_SLOTS{EMPTY_CODE}};
      for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= EMPTY_CODE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      dirty_q <= dirty_d;
      err_q   <= err_d;
      ids_q   <= ids_d;
      slots_q <= slots_d;
    end
  end

  assign product_IDS = ids_q;
  assign item_count  = count_q;
  assign full        = (count_q == NS);
  assign empty       = (count_q == 4'd0);
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign del_ready   = (state_q == IDLE) && !clr;
  assign add_ready   = (state_q == IDLE) && !full && !clr && !del_valid;

endmodule

// File: tb/tb_product_list_scheduler.sv
// Directed vector table plus randomized traffic against a list-level model.
module tb_product_list_scheduler;

  logic        CLK = 1'b0;
  logic        RST, add_valid, add_ready, del_valid, del_ready, clr;
  logic [3:0]  add_id, del_index, item_count;
  logic [10:0] H_counter;
  logic [9:0]  V_counter;
  logic [47:0] product_IDS;
  logic        full, empty, busy, err;

  localparam logic [47:0] F = 48'hFFFF_FFFF_FFFF;

  product_list_scheduler dut (
    .CLK(CLK), .RST(RST),
    .add_valid(add_valid), .add_id(add_id), .add_ready(add_ready),
    .del_valid(del_valid), .del_index(del_index), .del_ready(del_ready),
    .clr(clr), .H_counter(H_counter), .V_counter(V_counter),
    .product_IDS(product_IDS), .item_count(item_count),
    .full(full), .empty(empty), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: the list as a queue; a delete produces its final list at once
  // and only becomes visible after the shift time has elapsed.
  int          q[$];
  int          pend[$];
  int          rem;
  logic        m_dirty, m_err;
  logic [47:0] m_ids;
  logic        last_ardy;

  function automatic logic [47:0] pack(input int l[$]);
    logic [47:0] r;
    r = F;
    for (int i = 0; i < l.size(); i++) r[47-4*i -: 4] = 4'(l[i]);
    return r;
  endfunction

  task automatic model_reset();
    q.delete(); pend.delete();
    rem = 0; m_dirty = 1'b0; m_err = 1'b0; m_ids = F;
  endtask

  task automatic step(input logic r, input logic c, input logic av, input logic [3:0] aid,
                      input logic dv, input logic [3:0] di, input logic [10:0] h,
                      input logic [9:0] v);
    logic e_ardy, e_drdy, bnd, e;
    @(negedge CLK);
    RST = r; clr = c; add_valid = av; add_id = aid; del_valid = dv; del_index = di;
    H_counter = h; V_counter = v;
    #1;
    e_ardy = (rem == 0) && (q.size() < 12) && !c && !dv;
    e_drdy = (rem == 0) && !c;
    chk("add_ready", {47'b0, add_ready}, {47'b0, e_ardy});
    chk("del_ready", {47'b0, del_ready}, {47'b0, e_drdy});
    last_ardy = add_ready;
    @(posedge CLK);
    bnd = (v == 10'd480) && (h == 11'd0);
    if (r) begin
      model_reset();
    end else begin
      e = 1'b0;
      if (bnd && rem == 0 && m_dirty) begin m_ids = pack(q); m_dirty = 1'b0; end
      if (c) begin
        q.delete(); rem = 0; m_dirty = 1'b1;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin q = pend; m_dirty = 1'b1; end
      end else if (dv) begin
        if (int'(di) >= q.size()) e = 1'b1;
        else begin pend = q; pend.delete(int'(di)); rem = q.size() - int'(di); end
      end else if (av && q.size() < 12) begin
        q.push_back(int'(aid)); m_dirty = 1'b1;
      end
      m_err = e;
    end
    #1;
    chk("m_ids",   product_IDS, m_ids);
    chk("m_count", {44'b0, item_count}, 48'(q.size()));
    chk("m_busy",  {47'b0, busy},  {47'b0, rem > 0});
    chk("m_err",   {47'b0, err},   {47'b0, m_err});
    chk("m_full",  {47'b0, full},  {47'b0, q.size() == 12});
    chk("m_empty", {47'b0, empty}, {47'b0, q.size() == 0});
  endtask

  typedef struct {
    logic r, c, av; logic [3:0] aid; logic dv; logic [3:0] di; logic bnd;
    logic e_ardy; logic [3:0] e_cnt; logic [47:0] e_ids; logic e_busy, e_err;
  } vec_t;
  vec_t tbl[$];

  task automatic vec(input string op, input int arg, input bit bnd, input bit ardy,
                     input int cnt, input logic [47:0] ids, input bit bsy, input bit er);
    vec_t t;
    logic [31:0] a;
    a = arg;
    t.r = (op == "rst"); t.c = (op == "clr"); t.av = (op == "add"); t.dv = (op == "del");
    t.aid = a[3:0]; t.di = a[3:0]; t.bnd = bnd; t.e_ardy = ardy;
    t.e_cnt = 4'(cnt); t.e_ids = ids; t.e_busy = bsy; t.e_err = er;
    tbl.push_back(t);
  endtask

  initial begin
    logic [47:0] C1, C2, C3, C4;
    C1 = 48'h123F_FFFF_FFFF; C2 = 48'h1245_6789_FFFF;
    C3 = 48'h2FFF_FFFF_FFFF; C4 = 48'h12FF_FFFF_FFFF;
    RST = 1'b1; clr = 1'b0; add_valid = 1'b0; add_id = 4'h0; del_valid = 1'b0;
    del_index = 4'h0; H_counter = 11'd100; V_counter = 10'd10;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ids",   product_IDS, F);
    chk("rst_count", {44'b0, item_count}, 48'd0);
    chk("rst_flags", {44'b0, full, empty, busy, err}, 48'b0100);

    // 3 adds, commit, out-of-range delete
    vec("add",1,0, 1,1,F,0,0);  vec("add",2,0, 1,2,F,0,0);  vec("add",3,0, 1,3,F,0,0);
    vec("nop",0,0, 1,3,F,0,0);  vec("nop",0,1, 1,3,C1,0,0);
    vec("del",5,0, 0,3,C1,0,1); vec("nop",0,0, 1,3,C1,0,0); vec("nop",0,1, 1,3,C1,0,0);
    // grow to 1..9, delete index 2 with a boundary during the shift
    for (int i = 4; i <= 9; i++) vec("add",i,0, 1,i,C1,0,0);
    vec("del",2,0, 0,9,C1,1,0);
    for (int j = 0; j < 6; j++) vec("nop",0,(j == 1), 0,9,C1,1,0);
    vec("nop",0,0, 0,8,C1,0,0); vec("nop",0,1, 1,8,C2,0,0);
    // clr in the second shift cycle
    vec("del",0,0, 0,8,C2,1,0); vec("nop",0,0, 0,8,C2,1,0);
    vec("clr",0,0, 0,0,C2,0,0); vec("nop",0,1, 1,0,F,0,0);
    // fill to 12 (last ID is the empty code), then a held add
    for (int i = 0; i <= 10; i++) vec("add",i,0, 1,i+1,F,0,0);
    vec("add",15,0, 1,12,F,0,0);
    vec("add",7,0, 0,12,F,0,0); vec("add",7,0, 0,12,F,0,0);
    // boundary coinciding with clr, then with add: pre-edit list committed
    vec("clr",0,1, 0,0,48'h0123_4567_89AF,0,0);
    vec("add",2,1, 1,1,F,0,0);  vec("nop",0,1, 1,1,C3,0,0);
    // delete of the only entry takes one cycle; delete on empty errs
    vec("del",0,0, 0,1,C3,1,0); vec("nop",0,0, 0,0,C3,0,0); vec("nop",0,1, 1,0,F,0,0);
    vec("del",0,0, 0,0,F,0,1);  vec("nop",0,0, 1,0,F,0,0);
    // reset mid-shift
    vec("add",1,0, 1,1,F,0,0);  vec("add",2,0, 1,2,F,0,0);  vec("nop",0,1, 1,2,C4,0,0);
    vec("add",3,0, 1,3,C4,0,0); vec("del",0,0, 0,3,C4,1,0); vec("nop",0,0, 0,3,C4,1,0);
    vec("rst",0,0, 0,0,F,0,0);  vec("nop",0,0, 1,0,F,0,0);

    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].c, tbl[k].av, tbl[k].aid, tbl[k].dv, tbl[k].di,
           tbl[k].bnd ? 11'd0 : 11'd100, tbl[k].bnd ? 10'd480 : 10'd10);
      chk($sformatf("v%0d_ardy", k),  {47'b0, last_ardy}, {47'b0, tbl[k].e_ardy});
      chk($sformatf("v%0d_count", k), {44'b0, item_count}, {44'b0, tbl[k].e_cnt});
      chk($sformatf("v%0d_ids", k),   product_IDS, tbl[k].e_ids);
      chk($sformatf("v%0d_busy", k),  {47'b0, busy}, {47'b0, tbl[k].e_busy});
      chk($sformatf("v%0d_err", k),   {47'b0, err},  {47'b0, tbl[k].e_err});
      chk($sformatf("v%0d_full", k),  {47'b0, full}, {47'b0, tbl[k].e_cnt == 4'd12});
    end

    for (int n = 0; n < 3000; n++) begin
      logic [10:0] h;
      logic [9:0]  v;
      int p;
      p = $urandom_range(0, 5);
      case (p)
        0: begin h = 11'd0; v = 10'd480; end
        1: begin h = 11'd1; v = 10'd480; end
        2: begin h = 11'd0; v = 10'd479; end
        default: begin h = 11'($urandom_range(2, 799)); v = 10'($urandom_range(0, 524)); end
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)), h, v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
